// File: rtl/rect_draw_engine_if.sv
// Command / pixel bus between the game controller (master) and rect_draw_engine (slave).
// Carries the flush strobe, the command handshake and the pixel stream towards the VGA adapter.
interface rect_draw_engine_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
);
    logic               flush;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [X_W-1:0]     cmd_x;
    logic [Y_W-1:0]     cmd_y;
    logic [X_W-1:0]     cmd_w;
    logic [Y_W-1:0]     cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic [1:0]         cmd_mode;
    logic               pix_ready;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               pix_plot;
    logic               busy;
    logic               done;

    modport master (
        output flush, cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mode, pix_ready,
        input  cmd_ready, pix_x, pix_y, pix_color, pix_plot, busy, done
    );

    modport slave (
        input  flush, cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mode, pix_ready,
        output cmd_ready, pix_x, pix_y, pix_color, pix_plot, busy, done
    );
endinterface

// File: rtl/rect_draw_engine.sv
// Queued pixel-plot engine for the 160x120 VGA adapter: filled rects, one pixel per cycle, with clipping.
// Define RDE_DIAG_EN to add 45-degree diagonals (mode 01 down-right, 10 down-left).
module rect_draw_engine #(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COLOR_W    = 3,
    parameter int X_MAX      = 160,
    parameter int Y_MAX      = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    rect_draw_engine_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Wide enough for x0+i, y0+i (i up to 2^X_W-1) and for x0-i to wrap far above X_MAX.
    localparam int S_W = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam logic [S_W-1:0] X_LIM = S_W'(X_MAX);
    localparam logic [S_W-1:0] Y_LIM = S_W'(Y_MAX);

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [X_W-1:0]     w;
        logic [Y_W-1:0]     h;
        logic [COLOR_W-1:0] color;
`ifdef RDE_DIAG_EN
        logic [1:0]         mode;
`endif
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t         r_state, w_next;
    cmd_t           r_mem [FIFO_DEPTH];
    logic [PTR_W:0] r_wr_ptr, r_rd_ptr;
    cmd_t           r_cur;
    logic [X_W-1:0] r_cx;
    logic [Y_W-1:0] r_cy;

    cmd_t           w_in, w_head;
    logic           w_empty, w_full, w_push, w_pop;
    logic           w_head_rect, w_head_zero, w_cur_rect;
    logic           w_row_end, w_col_end, w_last, w_adv, w_in_bounds;
    logic [S_W-1:0] w_x0, w_y0, w_cx, w_cy, w_px, w_py;

    always_comb begin
        w_in       = '0;
        w_in.x     = bus.cmd_x;
        w_in.y     = bus.cmd_y;
        w_in.w     = bus.cmd_w;
        w_in.h     = bus.cmd_h;
        w_in.color = bus.cmd_color;
`ifdef RDE_DIAG_EN
        w_in.mode  = bus.cmd_mode;
`endif
    end

`ifndef RDE_DIAG_EN
    logic w_unused_mode;
    assign w_unused_mode = ^bus.cmd_mode;
`endif

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
    // flush wins over a same-cycle push and blocks the pop
    assign w_push  = bus.cmd_valid && !w_full && !bus.flush;
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !bus.flush;

`ifdef RDE_DIAG_EN
    assign w_head_rect = !(w_head.mode == 2'b01 || w_head.mode == 2'b10);
    assign w_cur_rect  = !(r_cur.mode == 2'b01 || r_cur.mode == 2'b10);
`else
    assign w_head_rect = 1'b1;
    assign w_cur_rect  = 1'b1;
`endif
    assign w_head_zero = (w_head.w == '0) || (w_head_rect && w_head.h == '0);

    assign w_x0 = {{(S_W-X_W){1'b0}}, r_cur.x};
    assign w_y0 = {{(S_W-Y_W){1'b0}}, r_cur.y};
    assign w_cx = {{(S_W-X_W){1'b0}}, r_cx};
    assign w_cy = {{(S_W-Y_W){1'b0}}, r_cy};

    always_comb begin
        w_px = w_x0 + w_cx;
        w_py = w_y0 + w_cy;
`ifdef RDE_DIAG_EN
        if (!w_cur_rect) begin
            w_py = w_y0 + w_cx;
            if (r_cur.mode == 2'b10) w_px = w_x0 - w_cx;
        end
`endif
    end

    assign w_in_bounds = (w_px < X_LIM) && (w_py < Y_LIM);
    assign w_row_end   = (r_cx == r_cur.w - X_W'(1));
    assign w_col_end   = (r_cy == r_cur.h - Y_W'(1));
    assign w_last      = w_cur_rect ? (w_row_end && w_col_end) : w_row_end;
    // off-screen pixels never wait on the adapter
    assign w_adv       = (r_state == S_DRAW) && (bus.pix_ready || !w_in_bounds);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_next = w_head_zero ? S_DONE : S_DRAW;
            S_DRAW:  if (w_adv && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_in;
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cur    <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
        end else begin
            r_state <= w_next;
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_cur <= w_head;
                r_cx  <= '0;
                r_cy  <= '0;
            end else if (w_adv) begin
                if (w_cur_rect && w_row_end) begin
                    r_cx <= '0;
                    r_cy <= r_cy + Y_W'(1);
                end else begin
                    r_cx <= r_cx + X_W'(1);
                end
            end
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.pix_x     = w_px[X_W-1:0];
    assign bus.pix_y     = w_py[Y_W-1:0];
    assign bus.pix_color = r_cur.color;
    assign bus.pix_plot  = (r_state == S_DRAW) && w_in_bounds;
    assign bus.busy      = (r_state != S_IDLE) || !w_empty;
    assign bus.done      = (r_state == S_DONE);
endmodule

// File: tb/tb_rect_draw_engine.sv
// Bench for rect_draw_engine: directed cases with literal expectations plus randomized commands
// checked every cycle against a pixel-list model of each queued primitive.
module tb_rect_draw_engine;
    logic clk;
    logic resetn;
    rect_draw_engine_if bus ();

    rect_draw_engine dut (.clk(clk), .resetn(resetn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int x; int y; int c; int id;} pix_t;
    pix_t exp_q[$];
    int   exp_done[$];
    int   log_x[$], log_y[$];
    int   cyc = 0, n_chk = 0, n_fail = 0, next_id = 0;
    int   plot_cnt, done_cnt, first_vis, done_cyc, push_cyc;
    int   rdy_mode = 0;
    bit   prev_stall = 0;
    int   prev_pack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_eq(input string nm, input int act, input int exp);
        chk(act == exp, nm, act, exp);
    endtask

    // Expected pixel list of one command, straight from the drawing rules.
    task automatic add_cmd(input int x, input int y, input int w, input int h, input int c, input int m);
        int id;
        id = next_id++;
        exp_done.push_back(id);
`ifdef RDE_DIAG_EN
        if (m == 1 || m == 2) begin
            for (int i = 0; i < w; i++) begin
                int px, py;
                px = (m == 1) ? x + i : x - i;
                py = y + i;
                if (px >= 0 && px < 160 && py < 120) exp_q.push_back('{px, py, c, id});
            end
            return;
        end
`endif
        for (int r = 0; r < h; r++)
            for (int k = 0; k < w; k++)
                if (x + k < 160 && y + r < 120) exp_q.push_back('{x + k, y + r, c, id});
    endtask

    always @(negedge clk) begin
        int pk;
        pk = (int'(bus.pix_x) << 10) | (int'(bus.pix_y) << 3) | int'(bus.pix_color);
        if (resetn) begin
            exp_q.delete();
            exp_done.delete();
            prev_stall = 0;
        end else begin
            if (exp_done.size() > 0) chk_eq("busy", bus.busy, 1);
            if (bus.pix_plot) begin
                if (first_vis < 0) first_vis = cyc;
                if (exp_q.size() == 0) chk(1'b0, "plot_extra", pk, -1);
                else chk_eq("pixel", pk, (exp_q[0].x << 10) | (exp_q[0].y << 3) | exp_q[0].c);
                if (bus.pix_ready) begin
                    if (exp_q.size() > 0) exp_q.delete(0);
                    log_x.push_back(int'(bus.pix_x));
                    log_y.push_back(int'(bus.pix_y));
                    plot_cnt++;
                end
            end
            if (prev_stall && bus.pix_plot) chk_eq("stall_hold", pk, prev_pack);
            prev_stall = bus.pix_plot && !bus.pix_ready;
            prev_pack  = pk;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_done.size() == 0) chk(1'b0, "done_extra", 1, 0);
                else begin
                    int id;
                    id = exp_done.pop_front();
                    chk(exp_q.size() == 0 || exp_q[0].id != id, "done_early", exp_q.size(), 0);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready && !bus.flush)
                add_cmd(bus.cmd_x, bus.cmd_y, bus.cmd_w, bus.cmd_h, bus.cmd_color, bus.cmd_mode);
            if (bus.flush) begin
                exp_q.delete();
                exp_done.delete();
                prev_stall = 0;
            end
        end
    end

    // pix_ready: 0 = always 1, 1 = toggling 1010, 2 = random
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       bus.pix_ready = ~bus.pix_ready;
                2:       bus.pix_ready = 1'($urandom_range(0, 1));
                default: bus.pix_ready = 1'b1;
            endcase
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clr_stats();
        plot_cnt = 0; done_cnt = 0; first_vis = -1; done_cyc = -1;
        log_x.delete(); log_y.delete();
    endtask

    task automatic push_cmd(input int x, input int y, input int w, input int h, input int c, input int m);
        bit ok;
        int t;
        t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_x = 8'(x); bus.cmd_y = 7'(y); bus.cmd_w = 8'(w); bus.cmd_h = 7'(h);
        bus.cmd_color = 3'(c); bus.cmd_mode = 2'(m);
        do begin
            @(negedge clk);
            ok = bus.cmd_ready;
            if (ok) push_cyc = cyc;
            step();
            t++;
        end while (!ok && t < 2000);
        bus.cmd_valid = 1'b0;
        if (!ok) chk(1'b0, "push_timeout", t, 2000);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.busy && t < 5000) begin step(); t++; end
        if (t >= 5000) chk(1'b0, "idle_timeout", t, 5000);
        step();
    endtask

    initial begin
        resetn = 1'b1;
        bus.flush = 1'b0; bus.cmd_valid = 1'b0;
        bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
        bus.cmd_color = '0; bus.cmd_mode = '0;
        clr_stats();
        repeat (3) step();
        chk_eq("rst_pix_x", bus.pix_x, 0);
        chk_eq("rst_pix_y", bus.pix_y, 0);
        chk_eq("rst_pix_color", bus.pix_color, 0);
        chk_eq("rst_pix_plot", bus.pix_plot, 0);
        chk_eq("rst_busy", bus.busy, 0);
        chk_eq("rst_done", bus.done, 0);
        chk_eq("rst_cmd_ready", bus.cmd_ready, 1);
        resetn = 1'b0;
        step();

        // reset in the middle of a rect
        push_cmd(0, 0, 50, 2, 5, 0);
        repeat (5) step();
        chk_eq("middraw_plotting", bus.pix_plot, 1);
        resetn = 1'b1; #1;
        chk_eq("middraw_rst_plot", bus.pix_plot, 0);
        chk_eq("middraw_rst_done", bus.done, 0);
        repeat (2) step();
        resetn = 1'b0;
        step();
        chk_eq("middraw_ready", bus.cmd_ready, 1);
        chk_eq("middraw_busy", bus.busy, 0);

        // 2x3 rect
        clr_stats();
        push_cmd(100, 20, 2, 3, 1, 0);
        wait_idle();
        chk_eq("rect_plots", plot_cnt, 6);
        chk_eq("rect_first_xy", log_x[0] * 1000 + log_y[0], 100020);
        chk_eq("rect_last_xy", log_x[5] * 1000 + log_y[5], 101022);
        chk_eq("rect_latency", first_vis - push_cyc, 2);
        chk_eq("rect_done_time", done_cyc - first_vis, 6);
        chk_eq("rect_dones", done_cnt, 1);

        // clipping at the bottom-right corner
        clr_stats();
        push_cmd(158, 118, 4, 4, 6, 3);
        wait_idle();
        chk_eq("clip_plots", plot_cnt, 4);
        chk_eq("clip_last_xy", log_x[3] * 1000 + log_y[3], 159119);
        chk_eq("clip_done_time", done_cyc - first_vis, 16);

        // queue fills while the first command draws
        clr_stats();
        push_cmd(20, 20, 20, 2, 2, 0);
        step();
        push_cmd(0, 0, 2, 2, 3, 0);
        push_cmd(5, 5, 3, 1, 4, 0);
        push_cmd(9, 9, 0, 4, 5, 0);
        push_cmd(1, 1, 1, 1, 6, 0);
        chk_eq("queue_full_ready", bus.cmd_ready, 0);
        push_cmd(2, 2, 2, 1, 7, 0);
        wait_idle();
        chk_eq("queue_dones", done_cnt, 6);
        chk_eq("queue_plots", plot_cnt, 50);

        // stalls with pix_ready toggling
        clr_stats();
        rdy_mode = 1;
        push_cmd(10, 10, 4, 2, 3, 0);
        wait_idle();
        chk_eq("stall_plots", plot_cnt, 8);
        rdy_mode = 0;
        step();

        // flush mid-rect, with a same-cycle push that must be dropped
        clr_stats();
        push_cmd(0, 0, 30, 3, 1, 0);
        push_cmd(0, 50, 5, 5, 2, 0);
        repeat (10) step();
        bus.flush = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_x = 8'd5; bus.cmd_y = 7'd5; bus.cmd_w = 8'd2; bus.cmd_h = 7'd2;
        step();
        bus.flush = 1'b0; bus.cmd_valid = 1'b0;
        chk_eq("flush_plot", bus.pix_plot, 0);
        chk_eq("flush_busy", bus.busy, 0);
        chk_eq("flush_ready", bus.cmd_ready, 1);
        repeat (5) step();
        chk_eq("flush_no_done", done_cnt, 0);

        // down-left diagonal
        clr_stats();
        push_cmd(80, 40, 3, 1, 2, 2);
        wait_idle();
`ifdef RDE_DIAG_EN
        chk_eq("diag_plots", plot_cnt, 3);
        chk_eq("diag_last_xy", log_x[2] * 1000 + log_y[2], 78042);
`else
        chk_eq("diag_as_rect_plots", plot_cnt, 3);
        chk_eq("diag_as_rect_last_xy", log_x[2] * 1000 + log_y[2], 82040);
`endif
        clr_stats();
        push_cmd(1, 10, 3, 1, 2, 2);
        wait_idle();
`ifdef RDE_DIAG_EN
        chk_eq("diag_borrow_plots", plot_cnt, 2);
`else
        chk_eq("diag_borrow_as_rect_plots", plot_cnt, 3);
`endif

        // randomized commands, stalls and flushes
        rdy_mode = 2;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 14) == 0) begin
                bus.flush = 1'b1;
                step();
                bus.flush = 1'b0;
            end
            push_cmd($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 6),
                     $urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle();
        chk_eq("final_pixels_left", exp_q.size(), 0);
        chk_eq("final_dones_left", exp_done.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
